// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants (entry layout, instruction width, NOP encoding).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package fetch_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0); used as the filler inst field of PC tag entries.
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Generic synchronous FIFO of fetch_entry_t with flush; head is shown combinationally.
// Latency: a pushed entry is visible at head one cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so any depth works, not only powers of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset because empty gates every use of head.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, in-order imem requests, buffered {inst, pc} to decode, redirect flush.
// Latency: response to if_valid is 1 cycle; 0 cycles on an empty buffer when IF_BYPASS_EN is defined.
// Backpressure: if_ready low holds the head; requests stop once in-flight + buffered reach FIFO_DEPTH.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  // FIFO_DEPTH is a power of two >= 2 and MAX_OUTSTANDING <= FIFO_DEPTH.
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [OCW-1:0]  drop_cnt;
  logic [OCW-1:0]  outstanding;
  logic [FCW-1:0]  ifq_count;

  fetch_entry_t    tag_push_data;
  fetch_entry_t    tag_head;
  logic            tag_full;
  logic            tag_empty;

  fetch_entry_t    ifq_push_data;
  fetch_entry_t    ifq_head;
  logic            ifq_empty;
  logic            ifq_push;
  logic            ifq_pop;

  logic            credit_ok;
  logic            req_fire;
  logic            rsp_acc;
  logic            rsp_keep;
  logic            byp_take;

  logic            unused_tag_inst;
  logic            unused_ifq_full;

  // Issue only while every in-flight word is guaranteed a buffer slot on return.
  assign credit_ok      = ((int'(outstanding) + int'(ifq_count)) < FIFO_DEPTH) && !tag_full;
  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_acc  = imem_rsp_valid && !tag_empty;
  // Stale words (pre-redirect) and the word arriving with a redirect are discarded.
  assign rsp_keep = rsp_acc && (drop_cnt == '0) && !redirect_valid;

`ifdef IF_BYPASS_EN
  // An arriving word may go straight to decode when nothing older is buffered.
  assign byp_take = rsp_keep && ifq_empty;
`else
  assign byp_take = 1'b0;
`endif

  assign ifq_push_data = '{inst: imem_rsp_data, pc: tag_head.pc};
  assign ifq_push      = rsp_keep && !(byp_take && if_ready);
  assign ifq_pop       = if_valid && if_ready && !ifq_empty;

  // Tag queue: one entry per in-flight request, its count is the outstanding total.
  assign tag_push_data = '{inst: NOP_INST, pc: fetch_pc};

  inst_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (tag_push_data),
    .pop       (rsp_acc),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  // Instruction buffer feeding decode; a redirect clears it outright.
  inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (ifq_push),
    .push_data (ifq_push_data),
    .pop       (ifq_pop),
    .head      (ifq_head),
    .full      (unused_ifq_full),
    .empty     (ifq_empty),
    .count     (ifq_count)
  );

  assign unused_tag_inst = ^tag_head.inst;

  // PC advance and stale-response accounting; redirect outranks any other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
      drop_cnt <= outstanding - (rsp_acc ? OCW'(1) : OCW'(0));
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_acc && (drop_cnt != '0)) drop_cnt <= drop_cnt - OCW'(1);
    end
  end

  // Decode-facing view: buffer head, bypassed word, or idle values when empty.
  always_comb begin
    if_valid = !ifq_empty;
    if_inst  = ifq_head.inst;
    if_pc    = ifq_head.pc;
    if (ifq_empty) begin
      if_inst = '0;
      if_pc   = RESET_PC;
      if (byp_take) begin
        if_valid = 1'b1;
        if_inst  = imem_rsp_data;
        if_pc    = tag_head.pc;
      end
    end
  end

  assign if_pc_plus4 = if_pc + 32'd4;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage, directly upstream of decode and the immediate generator.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel plus an in-order response channel.
- Buffers returned words in a small FIFO and presents {inst, pc} to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum imem requests in flight; must be <= FIFO_DEPTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word-aligned fetch address; bits[1:0] always 0.
- imem_rsp_valid  in  1  response word valid; responses return in request order, one per accepted request.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  redirect the PC (taken branch/jump).
- redirect_pc  in  32  new PC; bits[1:0] ignored and forced to 0.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction.
- if_inst  out  32  instruction word (feeds decode and the immediate generator).
- if_pc  out  32  PC of if_inst.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.

Behaviour:
- Reset state:
  - fetch_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0, if_valid = 0, if_inst = 0, if_pc = RESET_PC.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING).
  - imem_addr = fetch_pc.
  - On a req handshake: fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0) and outstanding++.
  - The PC of each in-flight request is held in a tag queue of depth MAX_OUTSTANDING.
- Response:
  - On imem_rsp_valid with drop_cnt == 0: push {data, tagged pc} into the FIFO and decrement outstanding.
  - If drop_cnt > 0: discard the word and decrement both drop_cnt and outstanding.
  - Response latency to if_valid: 1 cycle (FIFO registered).
- Output:
  - if_valid = FIFO non-empty; head entry is driven on if_inst/if_pc.
  - Pop on if_valid && if_ready.
  - Outputs hold stable while if_valid && !if_ready.
- Redirect (priority over every other event in the same cycle):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; if_valid = 0 on the next cycle.
  - drop_cnt = outstanding minus any response that arrives in the same cycle; that response is itself discarded.
  - No request is issued in the redirect cycle; fetching resumes the following cycle.
- Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
- Full FIFO: no new requests are issued (credit rule above), so responses never overflow.
- imem_rsp_valid with outstanding == 0 is a protocol error; the response is ignored.
- Reset mid-operation: all state returns to reset values; in-flight responses after reset are ignored because outstanding == 0.

Optional Feature:
- Macro: IF_BYPASS_EN.
- Defined: when the FIFO is empty and a response (drop_cnt == 0) arrives, it drives if_valid/if_inst/if_pc combinationally in the same cycle. If if_ready is high it is consumed without entering the FIFO; otherwise it is pushed. Response-to-if_valid latency becomes 0.
- Undefined: all responses go through the FIFO; latency is 1 cycle.

Decomposition:
- Package fetch_pkg:
  - XLEN = 32.
  - NOP_INST = 32'h0000_0013.
  - typedef struct packed fetch_entry_t {logic [31:0] inst; logic [31:0] pc;}.
- One sub-module, inst_fifo: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count outputs. It is instantiated for both the instruction buffer and the PC tag queue.

Test Plan:
- Reset, then if_ready=1, imem_req_ready=1, 1-cycle memory -> imem_addr sequence 0x0, 0x4, 0x8; if_pc follows the same sequence, if_inst matches memory contents.
- if_ready held 0 -> at most FIFO_DEPTH=2 requests issued, then imem_req_valid=0; if_inst/if_pc stable; releasing if_ready resumes fetch in order.
- Redirect to 0x0000_0102 with 2 requests outstanding -> next imem_addr = 0x0000_0100; the 2 stale responses are dropped; first if_pc after the redirect = 0x100.
- Redirect in the same cycle as a response and an if pop -> that response is dropped, FIFO is empty next cycle, no duplicate or stale if_pc appears.
- Redirect to 0xFFFF_FFFC -> fetch order 0xFFFF_FFFC then 0x0000_0000; if_pc_plus4 = 0x0000_0000 for the first instruction.
- reset asserted mid-stream with 2 outstanding -> next cycle if_valid=0 and imem_addr=RESET_PC; late responses are ignored.
